// File: rtl/mem_bus_arbiter.sv
// Serialises the core's instruction and data bus ports onto one single-outstanding memory port.
// Ties between the two requesters alternate round-robin; exactly one transaction is in flight.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic [1:0]  dbg_state
);
  // Downstream handshake: a request transfers on any rising edge where m_valid && m_ready;
  // once m_valid rises, m_valid and every m_* field hold until that transfer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        sel_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  strobe_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  always_comb begin
    state_d       = state_q;
    sel_d         = last_grant_q;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'd0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'd0;
    m_valid       = 1'b0;
    m_addr        = 32'd0;
    m_size        = 3'd0;
    m_strobe      = 4'd0;
    m_wdata       = 32'd0;
    case (state_q)
      S_IDLE: begin
        // addr_ok is suppressed while reset is held so no grant is advertised that is then dropped
        if (!reset && (ireq_valid || dreq_valid)) begin
          sel_d         = (ireq_valid && dreq_valid) ? ~last_grant_q : dreq_valid;
          iresp_addr_ok = (sel_d == GNT_I);
          dresp_addr_ok = (sel_d == GNT_D);
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_valid  = 1'b1;
        m_addr   = addr_q;
        m_size   = size_q;
        m_strobe = strobe_q;
        m_wdata  = wdata_q;
        if (m_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_rvalid) state_d = S_RESP;
      end
      S_RESP: begin
        iresp_data_ok = (last_grant_q == GNT_I);
        dresp_data_ok = (last_grant_q == GNT_D);
        if (last_grant_q == GNT_I) iresp_data = rdata_q;
        else                       dresp_data = rdata_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_I;
      addr_q       <= 32'd0;
      size_q       <= 3'd0;
      strobe_q     <= 4'd0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_ISSUE) begin
        // last_grant_q doubles as the owner of the transaction now in flight
        last_grant_q <= sel_d;
        addr_q       <= (sel_d == GNT_D) ? dreq_addr   : ireq_addr;
        size_q       <= (sel_d == GNT_D) ? dreq_size   : 3'b010;
        strobe_q     <= (sel_d == GNT_D) ? dreq_strobe : 4'd0;
        wdata_q      <= (sel_d == GNT_D) ? dreq_data   : 32'd0;
      end
      if (state_q == S_WAIT && m_rvalid) rdata_q <= m_rdata;
    end
  end

  assign dbg_state = state_q;
endmodule
